// File: rtl/nco_clock_gen.sv
// nco_clock_gen: multi-channel fractional clock-enable generator.
// Each channel owns a phase accumulator that adds its programmable increment
// every refclk cycle. The carry out becomes a one-cycle tick (ce_out), and the
// accumulator MSB becomes a roughly 50% duty square wave (sq_out).
// A lock counter reports when the configuration has been quiet for
// LOCK_CYCLES cycles.
module nco_clock_gen #(
    parameter int NUM_CLOCKS  = 2,
    parameter int ACC_WIDTH   = 32,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_addr,
    input  logic [ACC_WIDTH-1:0]  cfg_inc,
    input  logic [NUM_CLOCKS-1:0] ch_enable,
    input  logic                  sync,
    output logic [NUM_CLOCKS-1:0] ce_out,
    output logic [NUM_CLOCKS-1:0] sq_out,
    output logic                  locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

    logic [ACC_WIDTH-1:0]  r_inc [NUM_CLOCKS];
    logic [ACC_WIDTH-1:0]  r_acc [NUM_CLOCKS];
    logic [ACC_WIDTH:0]    w_sum [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] r_ce;
    logic [NUM_CLOCKS-1:0] r_enPrev;
    logic [CNT_W-1:0]      r_lockCnt;
    logic                  r_locked;
    logic                  w_cfgValid;
    logic                  w_cfgEvent;

    // A write only counts when it addresses an existing channel; writes to
    // unused addresses must neither change state nor disturb the lock.
    assign w_cfgValid = cfg_we && (32'(cfg_addr) < 32'(NUM_CLOCKS));
    assign w_cfgEvent = w_cfgValid || sync || (ch_enable != r_enPrev);

    // One extra bit on each adder so the carry marks the wrap of the phase.
    always_comb begin
        for (int n = 0; n < NUM_CLOCKS; n++) begin
            w_sum[n] = {1'b0, r_acc[n]} + {1'b0, r_inc[n]};
        end
    end

    // Increment registers: written independently of enable and sync.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_CLOCKS; n++) begin
                r_inc[n] <= '0;
            end
        end else if (w_cfgValid) begin
            for (int n = 0; n < NUM_CLOCKS; n++) begin
                if (cfg_addr == 4'(n)) begin
                    r_inc[n] <= cfg_inc;
                end
            end
        end
    end

    // Phase accumulators: sync or a disabled channel forces phase zero,
    // otherwise add the increment and register the carry as the tick.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_CLOCKS; n++) begin
                r_acc[n] <= '0;
            end
            r_ce <= '0;
        end else begin
            for (int n = 0; n < NUM_CLOCKS; n++) begin
                if (sync || !ch_enable[n]) begin
                    r_acc[n] <= '0;
                    r_ce[n]  <= 1'b0;
                end else begin
                    r_acc[n] <= w_sum[n][ACC_WIDTH-1:0];
                    r_ce[n]  <= w_sum[n][ACC_WIDTH];
                end
            end
        end
    end

    // Lock tracking: restart on any config event, saturate at LOCK_CYCLES
    // and raise locked one cycle after the counter gets there.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_enPrev  <= '0;
            r_lockCnt <= '0;
            r_locked  <= 1'b0;
        end else begin
            r_enPrev <= ch_enable;
            if (w_cfgEvent) begin
                r_lockCnt <= '0;
                r_locked  <= 1'b0;
            end else if (r_lockCnt < LOCK_MAX) begin
                r_lockCnt <= r_lockCnt + 1'b1;
            end else begin
                r_locked <= 1'b1;
            end
        end
    end

    // Square outputs are just the accumulator MSBs, straight from registers.
    always_comb begin
        sq_out = '0;
        for (int n = 0; n < NUM_CLOCKS; n++) begin
            sq_out[n] = r_acc[n][ACC_WIDTH-1];
        end
    end

    assign ce_out = r_ce;
    assign locked = r_locked;

endmodule
